// File: rtl/vreg_loader.sv
// Vector register loader: packs a byte stream into VECTORSPERREG-lane vectors and writes
// them to consecutive registers. Optional macro VLOAD_LANE_REVERSE_EN reverses lane order.
module vreg_loader #(
  parameter int unsigned REGSIZE       = 15,
  parameter int unsigned VECTORSPERREG = 16,
  parameter int unsigned DATAWIDTH     = 8,
  parameter int unsigned REGSIZEINT    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [REGSIZEINT-1:0]              base_addr,
  input  logic [REGSIZEINT:0]                count,
  input  logic                               s_valid,
  input  logic [DATAWIDTH-1:0]               s_data,
  output logic                               s_ready,
  output logic                               we3,
  output logic [REGSIZEINT-1:0]              ra3,
  output logic [VECTORSPERREG*DATAWIDTH-1:0] wd3,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned VEC_W  = VECTORSPERREG * DATAWIDTH;
  localparam int unsigned LANE_W = (VECTORSPERREG > 1) ? $clog2(VECTORSPERREG) : 1;
  localparam int unsigned CNT_W  = REGSIZEINT + 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [LANE_W-1:0]     lane_q, lane_nxt;
  logic [REGSIZEINT-1:0] addr_q, addr_nxt;
  logic [CNT_W-1:0]      rem_q, rem_nxt;
  logic [VEC_W-1:0]      buf_q, buf_nxt;
  logic [VEC_W-1:0]      wd3_nxt;
  logic [REGSIZEINT-1:0] ra3_nxt;
  logic                  we3_nxt, ready_nxt, busy_nxt, done_nxt;
  int unsigned           lane_pos;

  // Physical lane for the current byte
  always_comb begin
`ifdef VLOAD_LANE_REVERSE_EN
    lane_pos = (VECTORSPERREG - 1) - 32'(lane_q);
`else
    lane_pos = 32'(lane_q);
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_q;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    buf_nxt   = buf_q;
    wd3_nxt   = wd3;
    ra3_nxt   = ra3;
    we3_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_nxt  = base_addr;
            rem_nxt   = count;
            lane_nxt  = '0;
            state_nxt = FILL;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        if (s_valid && s_ready) begin
          buf_nxt[lane_pos*DATAWIDTH +: DATAWIDTH] = s_data;
          if (lane_q == LANE_W'(VECTORSPERREG - 1)) begin
            state_nxt = WRITE;
            wd3_nxt   = buf_nxt;
            ra3_nxt   = addr_q;
            we3_nxt   = 1'b1;
          end else begin
            lane_nxt = lane_q + LANE_W'(1);
          end
        end
      end
      WRITE: begin
        addr_nxt = (addr_q == REGSIZEINT'(REGSIZE)) ? '0 : addr_q + REGSIZEINT'(1);
        rem_nxt  = rem_q - CNT_W'(1);
        lane_nxt = '0;
        if (rem_q == CNT_W'(1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = FILL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ready_nxt = (state_nxt == FILL);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lane_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      wd3     <= '0;
      ra3     <= '0;
      we3     <= 1'b0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      lane_q  <= lane_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      buf_q   <= buf_nxt;
      wd3     <= wd3_nxt;
      ra3     <= ra3_nxt;
      we3     <= we3_nxt;
      s_ready <= ready_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: doc/vreg_loader.md
VREG_LOADER -- requirements
Module: vreg_loader

Interface
REQ-001 The block SHALL have parameter REGSIZE, default 15, meaning the highest vector register index; registers are 0..REGSIZE.
REQ-002 The block SHALL have parameter VECTORSPERREG, default 16, meaning the number of lanes per vector register.
REQ-003 The block SHALL have parameter DATAWIDTH, default 8, meaning the lane width in bits.
REQ-004 The block SHALL have parameter REGSIZEINT, default 4, meaning the register address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle load request, sampled only in IDLE.
REQ-008 The block SHALL have port base_addr, input, REGSIZEINT bits: first destination register.
REQ-009 The block SHALL have port count, input, REGSIZEINT+1 bits: number of vectors to load.
REQ-010 The block SHALL have ports s_valid (input, 1), s_data (input, DATAWIDTH) and s_ready (output, 1): the sample stream; a byte transfers when s_valid and s_ready are both 1.
REQ-011 The block SHALL have ports we3 (output, 1), ra3 (output, REGSIZEINT) and wd3 (output, VECTORSPERREG*DATAWIDTH): the register-file write port.
REQ-012 The block SHALL have ports busy (output, 1): a load is in progress, and done (output, 1): one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, FILL, WRITE and DONE.
REQ-014 IDLE: start=1 with count!=0 SHALL latch base_addr and count and enter FILL; start=1 with count==0 SHALL pulse done on the next cycle and stay idle, issuing no write.
REQ-015 FILL: s_ready SHALL be 1; the k-th accepted byte (k=0..VECTORSPERREG-1) SHALL be stored in lane k, where lane k = wd3 bits [k*DATAWIDTH +: DATAWIDTH].
REQ-016 On acceptance of lane VECTORSPERREG-1, the FSM SHALL enter WRITE on the next cycle.
REQ-017 WRITE: we3 SHALL be 1 for exactly one cycle, with ra3 = current address, wd3 = packed vector, and s_ready = 0.
REQ-018 After WRITE, the address SHALL increment and wrap from REGSIZE to 0, and the remaining count SHALL decrement; the FSM SHALL enter DONE if the remaining count is 0, else FILL with lane counter cleared.
REQ-019 DONE: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-020 busy SHALL be 1 in FILL, WRITE and DONE, and 0 in IDLE; start SHALL be ignored while busy.
REQ-021 s_valid=0 in FILL SHALL stall without changing state or lane count; gaps of any length SHALL be allowed.
REQ-022 Throughput SHALL be VECTORSPERREG+1 cycles per vector with continuous s_valid; a load of N vectors ends with done exactly one cycle after the last we3.
REQ-023 wd3 and ra3 SHALL be registered and held stable outside WRITE; only we3 qualifies them.
REQ-024 count greater than REGSIZE+1 SHALL be honoured literally, wrapping and overwriting earlier registers.

Reset
REQ-025 rst=1 SHALL force IDLE, lane counter 0, address 0, remaining count 0, wd3 0, and we3, s_ready, busy and done all 0 on the next edge.
REQ-026 rst asserted mid-load SHALL abort with no further we3, discarding the partial vector.

Configuration
REQ-027 With macro VLOAD_LANE_REVERSE_EN defined, the k-th accepted byte SHALL go to lane VECTORSPERREG-1-k; without it, lane ordering SHALL be per REQ-015.
REQ-028 The macro SHALL have no effect on timing, handshake or addressing.

Verification
REQ-029 Scenario 1: rst, then start with base_addr=0, count=1, and bytes 0x00..0x0F streamed continuously -> exactly one we3 at ra3=0 with wd3=0x0F0E...0100; done asserted one cycle later.
REQ-030 Scenario 2: start with base_addr=14, count=3, all bytes 0xA5 -> three we3 pulses at ra3=14, 15, 0, each with wd3=0xA5 repeated 16 times.
REQ-031 Scenario 3: s_valid toggled 1/0 every cycle, count=1 -> we3 occurs 31 cycles after the first byte is accepted, and lane contents are unchanged by the gaps.
REQ-032 Scenario 4: start with count=0 -> done asserted one cycle later, no we3, busy stays 0.
REQ-033 Scenario 5: rst after 7 bytes of a load -> no we3; the next load with base_addr=2 writes correct data to ra3=2.
REQ-034 Scenario 6: same stimulus as Scenario 1 with VLOAD_LANE_REVERSE_EN defined -> wd3=0x000102...0E0F.
